piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per word serialized (WIDTH >= 2).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  WIDTH  parallel word to transmit, sampled only on an accepted load.
REQ-005 Port: load  input  1  request to accept din this cycle.
REQ-006 Port: ready  output  1  high when a load this cycle will be accepted.
REQ-007 Port: sout  output  1  serial data, one bit per clock, LSB first; drives the downstream serial-in shift register's sin.
REQ-008 Port: busy  output  1  high while a word bit is on sout.
REQ-009 Port: last  output  1  high while bit WIDTH-1 of the current word is on sout.

Function
REQ-010 The block SHALL implement FSM states IDLE and SHIFT, with sout, busy, last and ready as registered or state-decoded outputs with no combinational path from load or din.
REQ-011 Accept rule: load is accepted at a rising edge iff load=1 and ready=1; din SHALL be captured into an internal WIDTH-bit register at that edge.
REQ-012 ready SHALL equal (state==IDLE) OR (state==SHIFT AND bit count==WIDTH-1).
REQ-013 IDLE + accepted load -> SHIFT, bit count=0, sout=din[0] in the next cycle (latency 1 clock from the accepting edge).
REQ-014 In SHIFT with bit count k<WIDTH-1, each edge SHALL advance k to k+1 and present captured bit k+1 on sout.
REQ-015 In SHIFT with k==WIDTH-1 and an accepted load, the next edge SHALL present the new din[0] with k=0; streaming is gapless.
REQ-016 In SHIFT with k==WIDTH-1 and no accepted load, the next edge SHALL return to IDLE.
REQ-017 In IDLE, sout=0, busy=0 and last=0.
REQ-018 A load asserted in SHIFT with k<WIDTH-1 SHALL be ignored; the captured word and the count are unaffected.
REQ-019 Changes on din while not accepting SHALL have no effect on sout.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-021 Contract: after the edge that ends the cycle in which last=1, a downstream right-shifting serial-in register (sin into MSB) clocked on the same clk SHALL hold the full transmitted word.

Reset
REQ-022 reset=1 SHALL immediately force state=IDLE, bit count=0, the captured word register=0, sout=0, busy=0 and last=0, independent of clk.
REQ-023 While reset=1, ready SHALL be 1 and loads SHALL NOT be accepted.
REQ-024 Reset asserted mid-word SHALL abort the word; it SHALL NOT be resumed after release.
REQ-025 After reset deassertion, the first rising edge SHALL honour the accept rule normally.

Structure
REQ-026 Package piso_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the default WIDTH constant.
REQ-027 The bit counter (clear, increment, terminal-count flag at WIDTH-1) SHALL be a sub-module named bit_counter; all other logic stays in piso_tx.
REQ-028 The bench SHALL instantiate piso_tx feeding the team's 8-bit serial-in shift register (sout->sin, shared clk and reset) as the end-to-end checker.

Verification
REQ-029 Reset, then din=8'hA5 with load for one cycle -> sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles; last high on cycle 8 only; downstream q==8'hA5 after that edge; then IDLE with sout=0.
REQ-030 Load 8'hA5, then load 8'h3C during the A5 last cycle -> 16 contiguous bits with no idle cycle; downstream q==8'hA5, then q==8'h3C 8 clocks later.
REQ-031 Load 8'hFF, then pulse load with din=8'h00 at bit 3 -> the pulse is ignored, ready=0 at that time, and downstream q==8'hFF.
REQ-032 Load 8'hF0, assert reset asynchronously mid-clock at bit 4 -> sout, busy and last=0 immediately; after release, loading 8'h81 yields downstream q==8'h81.
REQ-033 Hold load=1 continuously with din stepping 8'h01, 8'h02, 8'h03 at each accepting edge -> back-to-back words 01, 02, 03 with busy continuously high and exactly one last pulse per word.

Source files
------------

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the parallel-in serial-out transmitter
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_tx_if.sv
// rtl/piso_tx_if.sv - word load handshake and serial output bundle for piso_tx
interface piso_tx_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             sout;
  logic             busy;
  logic             last;

  modport master (
    output din,
    output load,
    input  ready,
    input  sout,
    input  busy,
    input  last
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output sout,
    output busy,
    output last
  );

endinterface

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - bit index counter with synchronous clear and terminal-count flag
module bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - LSB-first serializer with gapless back-to-back word loading
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  piso_tx_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             accept;
  logic             shifting;
  logic             ready_c;
  logic             busy_c;
  logic             last_c;
  logic             sout_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word <= '0;
    end else if (accept) begin
      word <= bus.din;
    end
  end

  // Outputs depend only on state, count and the captured word; load only steers next_state.
  always_comb begin
    next_state = state;
    ready_c    = 1'b0;
    busy_c     = 1'b0;
    last_c     = 1'b0;
    sout_c     = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.load) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy_c  = 1'b1;
        sout_c  = word[count];
        last_c  = tc;
        ready_c = tc;
        if (tc && !bus.load) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign shifting = (state == SHIFT);
  assign accept   = bus.load && ready_c;

  bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (accept || (shifting && tc)),
    .inc   (shifting && !tc),
    .count (count),
    .tc    (tc)
  );

  assign bus.ready = ready_c;
  assign bus.busy  = busy_c;
  assign bus.last  = last_c;
  assign bus.sout  = sout_c;

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - scoreboard bench for piso_tx with a downstream serial-in register
module tb_piso_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) bus ();

  piso_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= {bus.sout, q[7:1]};
  end

  typedef struct {
    logic b;
    logic l;
  } exp_t;

  exp_t       bit_q[$];
  logic [7:0] word_q[$];
  int         rem = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the serial line either carries the next expected bit or is idle.
  initial begin
    exp_t       e;
    logic       pend;
    logic [7:0] pend_word;
    pend = 1'b0;
    pend_word = '0;
    forever begin
      @(negedge clk);
      if (reset) pend = 1'b0;
      if (pend) begin
        check("rx_word", q, pend_word);
        pend = 1'b0;
      end
      if (bit_q.size() > 0) begin
        e = bit_q.pop_front();
        check("busy", bus.busy, 1);
        check("sout", bus.sout, e.b);
        check("last", bus.last, e.l);
        if (e.l) begin
          pend = 1'b1;
          pend_word = word_q.pop_front();
        end
      end else begin
        check("idle_out", {bus.sout, bus.busy, bus.last}, 0);
      end
    end
  end

  // Model: rem counts bits of the current word still to appear, including the one on sout now.
  task automatic cycle(input logic ld, input logic [7:0] d);
    logic acc;
    @(negedge clk);
    #1;
    bus.load = ld;
    bus.din  = d;
    check("ready", bus.ready, (rem <= 1));
    acc = ld && (rem <= 1) && !reset;
    if (acc) begin
      for (int i = 0; i < W; i++) bit_q.push_back('{d[i], (i == W - 1)});
      word_q.push_back(d);
      rem = W;
    end else if (rem > 0) begin
      rem--;
    end
  endtask

  task automatic load_word(input logic [7:0] d);
    int n;
    n = 0;
    while (rem > 1 && n < 40) begin
      cycle(1'b0, 8'($urandom));
      n++;
    end
    cycle(1'b1, d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bit_q.size() > 0 || rem > 0) && n < 40) begin
      cycle(1'b0, 8'($urandom));
      n++;
    end
    repeat (2) cycle(1'b0, 8'($urandom));
  endtask

  task automatic hit_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_out", {bus.sout, bus.busy, bus.last}, 0);
    check("rst_ready", bus.ready, 1);
    bit_q.delete();
    word_q.delete();
    rem = 0;
    cycle(1'b1, 8'h55);
    @(negedge clk);
    #2;
    reset    = 1'b0;
    bus.load = 1'b0;
  endtask

  initial begin
    int w;
    int n;
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.din  = '0;
    #1;
    check("reset_out", {bus.sout, bus.busy, bus.last}, 0);
    check("reset_ready", bus.ready, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;

    load_word(8'hA5);
    drain();

    load_word(8'hA5);
    load_word(8'h3C);
    drain();

    load_word(8'hFF);
    repeat (3) cycle(1'b0, 8'($urandom));
    cycle(1'b1, 8'h00);
    drain();

    load_word(8'hF0);
    repeat (4) cycle(1'b0, 8'($urandom));
    hit_reset();
    load_word(8'h81);
    drain();

    w = 1;
    n = 0;
    while (w <= 3 && n < 50) begin
      if (rem <= 1) begin
        cycle(1'b1, 8'(w));
        w++;
      end else begin
        cycle(1'b1, 8'(w));
      end
      n++;
    end
    drain();

    repeat (400) begin
      if ($urandom_range(79) == 0) hit_reset();
      else cycle(($urandom_range(2) == 0), 8'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
